// File: rtl/lectura.sv
// Read sequencer for the RTC multiplexed AD bus: address phase, turnaround, data phase, byte capture.
// Latency: the completion pulse comes 2*T_SETUP+2*T_PULSO+T_ESPERA+T_SETUP edges after the start edge.
// Backpressure: none; start requests are only sampled in IDLE, and all inputs are ignored mid-transaction.
module lectura #(
  parameter int T_SETUP  = 2,
  parameter int T_PULSO  = 10,
  parameter int T_ESPERA = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] dir,
  input  logic       iniciar,
  input  logic [7:0] data_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       cs_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic [7:0] dir_out,
  output logic [7:0] dato_leido,
  output logic       lee,
  output logic       fin,     // transaction-complete pulse ("final" is a reserved word)
  output logic       activa
);

  // Counter reload values: each state lasts (reload + 1) cycles.
  localparam logic [7:0] CNT_SETUP  = 8'(T_SETUP - 1);
  localparam logic [7:0] CNT_PULSO  = 8'(T_PULSO - 1);
  localparam logic [7:0] CNT_ESPERA = 8'(T_ESPERA - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DIR_SETUP,
    ST_DIR_WR,
    ST_DIR_HOLD,
    ST_ESPERA,
    ST_LEE_RD,
    ST_LEE_HOLD,
    ST_FIN
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] dir_q, dir_d;
  logic [7:0] dato_q, dato_d;
  logic       cs_n_q, cs_n_d;
  logic       wr_n_q, wr_n_d;
  logic       rd_n_q, rd_n_d;
  logic       oe_q, oe_d;
  logic       lee_q, lee_d;
  logic       fin_q, fin_d;
  logic       activa_q, activa_d;

  // Next state, counter reload, latches, and outputs decoded from the state being entered
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    dato_d   = dato_q;

    if (state_q == ST_IDLE) begin
      if (iniciar) begin
        state_d = ST_DIR_SETUP;
        cnt_d   = CNT_SETUP;
        dir_d   = dir;
      end
    end else if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end else begin
      case (state_q)
        ST_DIR_SETUP: begin state_d = ST_DIR_WR;   cnt_d = CNT_PULSO;  end
        ST_DIR_WR:    begin state_d = ST_DIR_HOLD; cnt_d = CNT_SETUP;  end
        ST_DIR_HOLD:  begin state_d = ST_ESPERA;   cnt_d = CNT_ESPERA; end
        ST_ESPERA:    begin state_d = ST_LEE_RD;   cnt_d = CNT_PULSO;  end
        ST_LEE_RD: begin
          // Sample the bus at the end of the last rd_n-low cycle
          state_d = ST_LEE_HOLD;
          cnt_d   = CNT_SETUP;
          dato_d  = data_in;
        end
        ST_LEE_HOLD:  begin state_d = ST_FIN;      cnt_d = 8'd0;       end
        default:      begin state_d = ST_IDLE;     cnt_d = 8'd0;       end
      endcase
    end

    cs_n_d   = 1'b1;
    wr_n_d   = 1'b1;
    rd_n_d   = 1'b1;
    oe_d     = 1'b0;
    lee_d    = 1'b0;
    fin_d    = 1'b0;
    activa_d = 1'b1;
    case (state_d)
      ST_IDLE:      activa_d = 1'b0;
      ST_DIR_SETUP: begin cs_n_d = 1'b0; oe_d = 1'b1; end
      ST_DIR_WR:    begin cs_n_d = 1'b0; oe_d = 1'b1; wr_n_d = 1'b0; end
      ST_DIR_HOLD:  begin cs_n_d = 1'b0; oe_d = 1'b1; end
      ST_ESPERA:    ;
      ST_LEE_RD:    begin cs_n_d = 1'b0; rd_n_d = 1'b0; lee_d = 1'b1; end
      ST_LEE_HOLD:  cs_n_d = 1'b0;
      default:      fin_d = 1'b1;
    endcase
  end

  // State, counter and registered outputs; reset forces the bus idle immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 8'd0;
      dir_q    <= 8'd0;
      dato_q   <= 8'd0;
      cs_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      rd_n_q   <= 1'b1;
      oe_q     <= 1'b0;
      lee_q    <= 1'b0;
      fin_q    <= 1'b0;
      activa_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      dato_q   <= dato_d;
      cs_n_q   <= cs_n_d;
      wr_n_q   <= wr_n_d;
      rd_n_q   <= rd_n_d;
      oe_q     <= oe_d;
      lee_q    <= lee_d;
      fin_q    <= fin_d;
      activa_q <= activa_d;
    end
  end

  assign ad_out     = dir_q;
  assign dir_out    = dir_q;
  assign dato_leido = dato_q;
  assign cs_n       = cs_n_q;
  assign wr_n       = wr_n_q;
  assign rd_n       = rd_n_q;
  assign ad_oe      = oe_q;
  assign lee        = lee_q;
  assign fin        = fin_q;
  assign activa     = activa_q;

endmodule
